tail_biting_conv_encoder: RTL and testbench
===========================================

# tail_biting_conv_encoder

Rate-1/2, constraint-length-7 tail-biting convolutional encoder (G1 = 171 octal → X, G2 = 133 octal → Y) that sits directly downstream of the 15-bit randomizer. Its Enable and DataIn are driven by the randomizer's Enable and DataOut. It collects randomized bits into fixed-size blocks in a ping-pong buffer. It then emits one (X, Y) pair per clock for each bit, with the encoder state preloaded from the last 6 bits of the block so the trellis starts and ends in the same state.

## Interface
- BLOCK_BITS, 96, bits per FEC block; legal range 6..288.
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- Enable  in  1  DataIn is valid this cycle and is captured.
- DataIn  in  1  randomized input bit.
- frame_start  in  1  qualified by Enable; DataIn is bit 0 of a new block.
- DataOutX  out  1  G1 (171) coded bit.
- DataOutY  out  1  G2 (133) coded bit.
- out_valid  out  1  DataOutX/DataOutY valid this cycle.
- out_first  out  1  pair k = 0 of a block.
- out_last  out  1  pair k = BLOCK_BITS-1 of a block.

## Operation
- Two banks of BLOCK_BITS bits.
  - Per-bank flag: FREE or FULL.
  - Fill pointer wptr, 0..BLOCK_BITS-1.
  - Fill-bank select fsel.
- Fill path, on each Enable:
  - The bit is written to bank[fsel][wptr], or to [0] if frame_start.
  - wptr increments, or is set to 1 if frame_start.
- frame_start discards any partially filled bits in the fill bank, so the block restarts at index 0.
- When the bit at index BLOCK_BITS-1 is written:
  - the bank is marked FULL,
  - fsel toggles,
  - wptr returns to 0.
- Encoder FSM states: IDLE and RUN.
  - IDLE→RUN when any bank is FULL. On that edge the encoder loads delay line d1..d6 = b[N-1], b[N-2], …, b[N-6] (d1 most recent), then registers pair 0.
  - RUN: counter k runs 0..N-1.
  - At k = N-1, the bank is freed.
  - If the other bank is FULL, the FSM goes straight to RUN for that bank, with no idle cycle. Otherwise it returns to IDLE.
- Code equations for input u = b[k]:
  - X = u ^ d1 ^ d2 ^ d3 ^ d6
  - Y = u ^ d2 ^ d3 ^ d5 ^ d6
  - After each pair the delay line shifts: d6←d5 … d2←d1, d1←u.
- Tail-biting invariant: the delay line after pair N-1 equals the preload value.
- Outputs are registered. DataOutX, DataOutY, out_first and out_last are 0 whenever out_valid = 0.
- Overflow cannot occur. Input is at most 1 bit/cycle and output is exactly 1 pair/cycle, so a bank finishes encoding no later than the other bank fills. No overflow flag exists.
- Reset values: out_valid, DataOutX, DataOutY, out_first, out_last = 0; both banks FREE; fsel = 0; wptr = 0; FSM IDLE.

## Timing
- Latency: the edge E0 captures bit N-1. Edge E0+1 loads the state and registers pair 0. Pair k is visible in the cycle after edge E0+1+k.
- out_valid stays high for exactly N consecutive cycles per block.
- Back-to-back blocks with Enable continuously high give an unbroken out_valid with no bubble. Pair 0 of block j+1 directly follows pair N-1 of block j.
- Gaps in Enable delay block completion only. Output of a started block is never stalled.
- frame_start during RUN affects only the fill bank; the encoding bank is unaffected.
- Enable with frame_start on the same cycle the fill bank would complete: frame_start wins. The bit goes to index 0 and the bank is not marked FULL.
- reset mid-block or mid-encode: outputs are 0 starting the cycle after the reset edge. Partial and FULL banks are discarded.

## Test plan
- Reset: hold reset 3 cycles with Enable = 1 and DataIn toggling. Required: out_valid = 0, all outputs 0, and no output for the next N-1 Enable cycles after reset release.
- All-zero block, N = 96, Enable continuous. Required:
  - out_valid high for 96 cycles, starting 2 edges after the last bit is captured;
  - X = Y = 0 throughout;
  - out_first on k = 0, out_last on k = 95.
- Impulse at b[0], all other bits 0. Required:
  - pairs k = 0..6 are X = 1,1,1,1,0,0,1 and Y = 1,0,1,1,0,1,1;
  - all other pairs are 0.
- Tail-bite wrap, impulse at b[95]. Required:
  - pairs k = 0..5 are X = 1,1,1,0,0,1 and Y = 0,1,1,0,1,1;
  - k = 95 is X = Y = 1;
  - all other pairs are 0.
- Two random blocks back-to-back, then a third block with Enable at 50% duty. Required:
  - output matches the golden model;
  - out_valid is continuous for blocks 0–1;
  - the block 2 output starts 2 edges after its last bit.
- frame_start asserted at fill index 40, followed by 96 bits equal to the impulse case. Required: the output equals the b[0]-impulse result, and the first 40 bits produce no output.

Source files
------------

// File: rtl/tail_biting_conv_encoder_if.sv
// Bit-serial port bundle between the randomizer and the tail-biting encoder.
// The master is the upstream randomizer side; the slave is the encoder.
interface tail_biting_conv_encoder_if;
    logic Enable;
    logic DataIn;
    logic frame_start;
    logic DataOutX;
    logic DataOutY;
    logic out_valid;
    logic out_first;
    logic out_last;

    modport master (
        output Enable, DataIn, frame_start,
        input  DataOutX, DataOutY, out_valid, out_first, out_last
    );

    modport slave (
        input  Enable, DataIn, frame_start,
        output DataOutX, DataOutY, out_valid, out_first, out_last
    );
endinterface

// File: rtl/tail_biting_conv_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (G1=171 -> X, G2=133 -> Y).
// Input bits fill a ping-pong pair of blocks; each full block is encoded one pair per clock.
//   state | meaning
//   IDLE  | no full bank pending; a full bank loads the delay line and emits pair 0
//   RUN   | emitting pair k_q of bank esel_q from the running delay line
module tail_biting_conv_encoder #(
    parameter int BLOCK_BITS = 96
) (
    input  logic                        clock,
    input  logic                        reset,
    tail_biting_conv_encoder_if.slave   bus
);
    localparam int PW = $clog2(BLOCK_BITS);
    localparam logic [PW-1:0] LAST = PW'(BLOCK_BITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [BLOCK_BITS-1:0] bank_q [2];
    logic [BLOCK_BITS-1:0] bank_d [2];
    logic [1:0]            full_q, full_d;
    logic                  fsel_q, fsel_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic                  esel_q, esel_d;
    logic [PW-1:0]         k_q, k_d;
    logic [5:0]            dl_q, dl_d;
    logic                  x_q, x_d, y_q, y_d;
    logic                  valid_q, valid_d, first_q, first_d, last_q, last_d;

    logic                  fill_done;
    logic                  emit;
    logic                  u;
    logic [5:0]            src;

    // dl[0] is d1 (most recent); preload takes the last six bits of the block.
    function automatic logic [5:0] preload(input logic [BLOCK_BITS-1:0] b);
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = b[BLOCK_BITS-1-i];
        return p;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            fsel_q    <= 1'b0;
            wptr_q    <= '0;
            esel_q    <= 1'b0;
            k_q       <= '0;
            dl_q      <= '0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            full_q    <= full_d;
            fsel_q    <= fsel_d;
            wptr_q    <= wptr_d;
            esel_q    <= esel_d;
            k_q       <= k_d;
            dl_q      <= dl_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    // Fill path; frame_start takes priority over completing the bank.
    always_comb begin
        bank_d    = bank_q;
        fsel_d    = fsel_q;
        wptr_d    = wptr_q;
        fill_done = 1'b0;
        if (bus.Enable) begin
            if (bus.frame_start) begin
                bank_d[fsel_q][0] = bus.DataIn;
                wptr_d            = PW'(1);
            end else begin
                bank_d[fsel_q][wptr_q] = bus.DataIn;
                if (wptr_q == LAST) begin
                    fill_done = 1'b1;
                    fsel_d    = ~fsel_q;
                    wptr_d    = '0;
                end else begin
                    wptr_d = wptr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[esel_q]) state_d = RUN;
            RUN:     if (k_q == LAST && !full_q[~esel_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // k_q is zero in IDLE, so the same index serves the load cycle and RUN.
    always_comb begin
        full_d  = full_q;
        esel_d  = esel_q;
        k_d     = k_q;
        dl_d    = dl_q;
        x_d     = 1'b0;
        y_d     = 1'b0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (fill_done) full_d[fsel_q] = 1'b1;
        src  = (state_q == IDLE) ? preload(bank_q[esel_q]) : dl_q;
        u    = bank_q[esel_q][k_q];
        emit = (state_q == RUN) || full_q[esel_q];
        if (emit) begin
            x_d     = u ^ src[0] ^ src[1] ^ src[2] ^ src[5];
            y_d     = u ^ src[1] ^ src[2] ^ src[4] ^ src[5];
            valid_d = 1'b1;
            first_d = (k_q == '0);
            last_d  = (k_q == LAST);
            dl_d    = {src[4:0], u};
            if (k_q == LAST) begin
                // Preload the other bank now so a pending block starts with no bubble.
                full_d[esel_q] = 1'b0;
                esel_d         = ~esel_q;
                k_d            = '0;
                dl_d           = preload(bank_q[~esel_q]);
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    assign bus.DataOutX  = x_q;
    assign bus.DataOutY  = y_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_tail_biting_conv_encoder.sv
// Directed bench for the tail-biting encoder: a scoreboard queue is filled with
// golden pairs whenever a block completes and is drained by a negedge monitor.
module tb_tail_biting_conv_encoder;
    localparam int N = 96;

    logic clock = 1'b0;
    logic reset = 1'b0;

    tail_biting_conv_encoder_if bus();

    tail_biting_conv_encoder #(.BLOCK_BITS(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];
    int         first_cyc_q [$];
    logic       blk [N];
    logic       src_blk [N];
    int         widx = 0;
    bit         mon_en = 1'b0;
    int         run_len = 0;

    // Golden model: circular convolution over the block, independent of any delay line.
    task automatic push_block();
        logic x, y;
        for (int k = 0; k < N; k++) begin
            x = blk[k] ^ blk[(k+N-1)%N] ^ blk[(k+N-2)%N] ^ blk[(k+N-3)%N] ^ blk[(k+N-6)%N];
            y = blk[k] ^ blk[(k+N-2)%N] ^ blk[(k+N-3)%N] ^ blk[(k+N-5)%N] ^ blk[(k+N-6)%N];
            exp_q.push_back({x, y, (k == 0), (k == N-1)});
        end
        first_cyc_q.push_back(cyc + 2);
    endtask

    task automatic drive(input logic en, input logic b, input logic fs);
        @(posedge clock);
        #1;
        bus.Enable      = en;
        bus.DataIn      = b;
        bus.frame_start = fs;
        if (en) begin
            if (fs) widx = 0;
            blk[widx] = b;
            if (widx == N-1) begin
                push_block();
                widx = 0;
            end else begin
                widx++;
            end
        end
    endtask

    task automatic send_src(input bit half_duty, input bit fs_first);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, src_blk[i], fs_first && (i == 0));
            if (half_duty) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic set_impulse(input int pos);
        for (int i = 0; i < N; i++) src_blk[i] = (i == pos);
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) src_blk[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset           = 1'b1;
        bus.Enable      = 1'b1;
        bus.DataIn      = 1'b0;
        bus.frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            mon_en = 1'b1;
            exp_q.delete();
            first_cyc_q.delete();
            widx = 0;
            checks++;
            assert ({bus.out_valid, bus.DataOutX, bus.DataOutY, bus.out_first, bus.out_last} === 5'b0)
            else begin
                errors++;
                $error("FAIL reset_outputs: got %b expected 00000",
                       {bus.out_valid, bus.DataOutX, bus.DataOutY, bus.out_first, bus.out_last});
            end
            bus.DataIn = ~bus.DataIn;
        end
        reset      = 1'b0;
        bus.Enable = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) drive(1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL drain_timeout: %0d pairs outstanding, expected 0", exp_q.size());
        end
    endtask

    always @(negedge clock) begin
        logic [3:0] e;
        logic [3:0] got;
        int         ef;
        if (mon_en) begin
            got = {bus.DataOutX, bus.DataOutY, bus.out_first, bus.out_last};
            if (bus.out_valid === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_valid: out_valid=1 at cycle %0d, expected 0", cyc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (got === e)
                    else begin
                        errors++;
                        $error("FAIL pair_xy_first_last: got %b expected %b at cycle %0d", got, e, cyc);
                    end
                end
                if (bus.out_first === 1'b1) begin
                    run_len = 1;
                    if (first_cyc_q.size() != 0) begin
                        ef = first_cyc_q.pop_front();
                        checks++;
                        assert (cyc == ef)
                        else begin
                            errors++;
                            $error("FAIL first_latency: pair 0 at cycle %0d expected cycle %0d", cyc, ef);
                        end
                    end
                end else begin
                    run_len++;
                end
                if (bus.out_last === 1'b1) begin
                    checks++;
                    assert (run_len == N)
                    else begin
                        errors++;
                        $error("FAIL valid_run_length: got %0d expected %0d", run_len, N);
                    end
                end
            end else begin
                run_len = 0;
                checks++;
                assert ({bus.out_valid, got} === 5'b0)
                else begin
                    errors++;
                    $error("FAIL idle_outputs: got %b expected 00000", {bus.out_valid, got});
                end
            end
        end
    end

    initial begin
        bus.Enable      = 1'b0;
        bus.DataIn      = 1'b0;
        bus.frame_start = 1'b0;

        do_reset(3);

        // All-zero block, then both impulse cases and two random blocks, all back-to-back.
        for (int i = 0; i < N; i++) src_blk[i] = 1'b0;
        send_src(1'b0, 1'b0);
        set_impulse(0);
        send_src(1'b0, 1'b0);
        set_impulse(N-1);
        send_src(1'b0, 1'b0);
        set_random();
        send_src(1'b0, 1'b0);
        set_random();
        send_src(1'b0, 1'b0);
        set_random();
        send_src(1'b1, 1'b0);
        drain(400);

        // frame_start after a partial fill of 40 bits and on the would-complete bit.
        set_random();
        send_src(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        set_impulse(0);
        send_src(1'b0, 1'b1);
        for (int i = 0; i < N-1; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        set_impulse(0);
        send_src(1'b0, 1'b1);
        drain(400);

        // Reset mid-encode with a partially filled second bank.
        set_random();
        send_src(1'b0, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        do_reset(2);
        set_impulse(N-1);
        send_src(1'b0, 1'b0);
        drain(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
